// File: rtl/tetris_pkg.sv
// Shared types and constants for the game controller and playfield stages.
package tetris_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSpawn,
    StPlay,
    StOver
  } game_state_e;

  localparam int unsigned NUM_BLOCKS   = 7;
  localparam int unsigned SCORE_W      = 16;
  localparam int unsigned LEVEL_W      = 4;
  localparam logic [9:0]  RO_NONE      = 10'd0;
  localparam logic [9:0]  RO_CW        = 10'd1;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  // Fold the raw 3-bit LFSR slice onto the valid piece range (7 -> 0).
  function automatic logic [2:0] piece_index(logic [2:0] raw);
    return (raw >= 3'(NUM_BLOCKS)) ? 3'd0 : raw;
  endfunction

endpackage

// File: rtl/game_lfsr.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11) with piece-index mapping.
module game_lfsr
  import tetris_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [2:0] piece
);

  // An all-zero seed would lock the LFSR up.
  localparam logic [15:0] START = (SEED == 16'd0) ? DEFAULT_SEED : SEED;

  logic [15:0] lfsr_q;
  logic        feedback;

  assign feedback = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  // Advance every cycle regardless of game state.
  always_ff @(posedge clk) begin
    if (!rst_n) lfsr_q <= START;
    else        lfsr_q <= {lfsr_q[14:0], feedback};
  end

  assign piece = piece_index(lfsr_q[2:0]);

endmodule

// File: rtl/game_ctrl.sv
// Game controller: button edges to move strobes, gravity, piece selection,
// score and level. Define GAME_CTRL_LEVEL_EN to enable level-based speed-up.
module game_ctrl
  import tetris_pkg::*;
#(
  parameter int unsigned GRAVITY_TICKS = 25_000_000,
  parameter int unsigned MIN_TICKS     = 1_000_000,
  parameter int unsigned LEVEL_STEP    = 100,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               btn_left,
  input  logic               btn_right,
  input  logic               btn_down,
  input  logic               btn_rot,
  input  logic               btn_start,
  input  logic               next_block,
  input  logic               gameover,
  input  logic [9:0]         score_plus,
  output logic               left,
  output logic               right,
  output logic               down,
  output logic [9:0]         ro,
  output logic [9:0]         block_num,
  output logic [SCORE_W-1:0] score,
  output logic [LEVEL_W-1:0] level,
  output logic               playing,
  output logic               over
);

  game_state_e        state_q;
  logic [4:0]         btn_q;
  logic               next_q;
  logic               armed_q;
  logic [4:0]         btn_now;
  logic [4:0]         btn_rise;
  logic               next_rise;
  logic [31:0]        grav_cnt_q;
  logic [31:0]        period;
  logic               grav_wrap;
  logic [2:0]         lfsr_piece;
  logic [SCORE_W:0]   score_sum;
  logic               score_we;
  logic [SCORE_W-1:0] score_new;

  game_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .piece (lfsr_piece)
  );

  assign btn_now = {btn_start, btn_rot, btn_down, btn_right, btn_left};

  // Previous levels sampled every cycle; armed_q masks the first cycle after
  // reset so a button held through reset does not count as a press.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_q   <= '0;
      next_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      btn_q   <= btn_now;
      next_q  <= next_block;
      armed_q <= 1'b1;
    end
  end

  assign btn_rise  = btn_now & ~btn_q & {5{armed_q}};
  assign next_rise = next_block & ~next_q & armed_q;
  assign grav_wrap = (grav_cnt_q >= period - 32'd1);

  // Score write enable and value shared by the FSM and the level tracker.
  always_comb begin
    score_sum = {1'b0, score} + {{(SCORE_W - 10){1'b0}}, score_plus};
    score_we  = 1'b0;
    score_new = score;
    unique case (state_q)
      StIdle, StOver: begin
        if (btn_rise[4]) begin
          score_we  = 1'b1;
          score_new = '0;
        end
      end
      StPlay: begin
        if (!gameover && next_rise) begin
          score_we  = 1'b1;
          score_new = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
        end
      end
      default: ;
    endcase
  end

`ifdef GAME_CTRL_LEVEL_EN
  logic [LEVEL_W-1:0] level_q;
  logic [31:0]        shifted;

  // Count of LEVEL_STEP thresholds reached, capped at 15.
  function automatic logic [LEVEL_W-1:0] level_of(logic [SCORE_W-1:0] s);
    logic [LEVEL_W-1:0] lvl;
    lvl = '0;
    for (int unsigned k = 1; k <= 15; k++) begin
      if (32'(s) >= k * LEVEL_STEP) lvl = LEVEL_W'(k);
    end
    return lvl;
  endfunction

  // Level only moves when score is written, so both update together.
  always_ff @(posedge clk) begin
    if (!rst_n)        level_q <= '0;
    else if (score_we) level_q <= level_of(score_new);
  end

  // Gravity period halves per level, floored at MIN_TICKS.
  always_comb begin
    shifted = 32'(GRAVITY_TICKS) >> level_q;
    period  = (shifted > 32'(MIN_TICKS)) ? shifted : 32'(MIN_TICKS);
  end

  assign level = level_q;
`else
  // Level parameters have no effect in this build.
  logic unused_level_cfg;
  assign unused_level_cfg = ^{32'(MIN_TICKS), 32'(LEVEL_STEP)};
  assign level            = '0;
  assign period           = 32'(GRAVITY_TICKS);
`endif

  // Main game FSM with registered strobes and status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      left       <= 1'b0;
      right      <= 1'b0;
      down       <= 1'b0;
      ro         <= RO_NONE;
      block_num  <= '0;
      score      <= '0;
      playing    <= 1'b0;
      over       <= 1'b0;
      grav_cnt_q <= '0;
    end else begin
      left  <= 1'b0;
      right <= 1'b0;
      down  <= 1'b0;
      ro    <= RO_NONE;
      if (score_we) score <= score_new;
      unique case (state_q)
        StIdle: begin
          if (btn_rise[4]) state_q <= StSpawn;
        end
        StSpawn: begin
          block_num  <= {7'd0, lfsr_piece};
          grav_cnt_q <= '0;
          if (gameover) begin
            state_q <= StOver;
            over    <= 1'b1;
          end else begin
            state_q <= StPlay;
            playing <= 1'b1;
          end
        end
        StPlay: begin
          if (gameover) begin
            state_q <= StOver;
            playing <= 1'b0;
            over    <= 1'b1;
          end else if (next_rise) begin
            state_q <= StSpawn;
            playing <= 1'b0;
          end else if (btn_rise[2] || grav_wrap) begin
            // Button and gravity drop merge into one pulse.
            down       <= 1'b1;
            grav_cnt_q <= '0;
          end else begin
            grav_cnt_q <= grav_cnt_q + 32'd1;
            if (btn_rise[3])      ro    <= RO_CW;
            else if (btn_rise[0]) left  <= 1'b1;
            else if (btn_rise[1]) right <= 1'b1;
          end
        end
        StOver: begin
          if (btn_rise[4]) begin
            state_q <= StSpawn;
            over    <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl: directed scenarios plus randomized play.
module tb_game_ctrl;

  localparam int unsigned G_TICKS = 64;
  localparam int unsigned M_TICKS = 4;
  localparam int unsigned L_STEP  = 100;
  localparam logic [15:0] SEED    = 16'hBEEF;
  localparam int          SEQ_N   = 8192;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_left, btn_right, btn_down, btn_rot, btn_start;
  logic       next_block, gameover;
  logic [9:0] score_plus;
  logic       left, right, down;
  logic [9:0] ro, block_num;
  logic [15:0] score;
  logic [3:0] level;
  logic       playing, over;

  game_ctrl #(
    .GRAVITY_TICKS (G_TICKS),
    .MIN_TICKS     (M_TICKS),
    .LEVEL_STEP    (L_STEP),
    .LFSR_SEED     (SEED)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_down   (btn_down),
    .btn_rot    (btn_rot),
    .btn_start  (btn_start),
    .next_block (next_block),
    .gameover   (gameover),
    .score_plus (score_plus),
    .left       (left),
    .right      (right),
    .down       (down),
    .ro         (ro),
    .block_num  (block_num),
    .score      (score),
    .level      (level),
    .playing    (playing),
    .over       (over)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          n_edges = 0;
  logic [15:0] seq [SEQ_N];
  int          m_score;
  int          g;
  logic        lv_l, lv_r, lv_d, lv_rt;

  always @(posedge clk) begin
    if (!rst_n) n_edges <= 0;
    else        n_edges <= n_edges + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [15:0] lfsr_next(logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  function automatic int exp_level(int s);
`ifdef GAME_CTRL_LEVEL_EN
    return (s / int'(L_STEP) > 15) ? 15 : s / int'(L_STEP);
`else
    return 0;
`endif
  endfunction

  function automatic int exp_period(int s);
`ifdef GAME_CTRL_LEVEL_EN
    int p;
    p = int'(G_TICKS) >> exp_level(s);
    return (p < int'(M_TICKS)) ? int'(M_TICKS) : p;
`else
    return int'(G_TICKS);
`endif
  endfunction

  function automatic logic [12:0] strobes();
    return {left, right, down, ro};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Piece latched at the most recent edge, from the LFSR value held before it.
  task automatic chk_block(input string tag);
    logic [15:0] v;
    int          idx;
    v   = (n_edges >= 1 && n_edges <= SEQ_N) ? seq[n_edges - 1] : 16'd0;
    idx = (v[2:0] == 3'd7) ? 0 : int'(v[2:0]);
    chk(tag, 32'(block_num), 32'(idx));
    chk({tag, "_range"}, 32'(block_num < 10'd7), 32'd1);
  endtask

  // One PLAY cycle: drive levels, arbitrate requests, compare strobes.
  task automatic play_step(input logic bl, input logic br, input logic bd, input logic brt);
    logic        el, er, ed, ert;
    logic [12:0] expv;
    el = bl & ~lv_l; er = br & ~lv_r; ed = bd & ~lv_d; ert = brt & ~lv_rt;
    btn_left = bl; btn_right = br; btn_down = bd; btn_rot = brt;
    lv_l = bl; lv_r = br; lv_d = bd; lv_rt = brt;
    expv = '0;
    if (ed || (g + 1 >= exp_period(m_score))) begin
      expv[10] = 1'b1;
      g = 0;
    end else begin
      g++;
      if (ert)     expv[9:0] = 10'd1;
      else if (el) expv[12]  = 1'b1;
      else if (er) expv[11]  = 1'b1;
    end
    tick();
    chk("play_strobes", 32'(strobes()), 32'(expv));
  endtask

  // Count idle PLAY cycles until the next gravity drop.
  task automatic measure_gravity(input string tag);
    int n;
    n = 0;
    do begin
      play_step(1'b0, 1'b0, 1'b0, 1'b0);
      n++;
    end while (!down && n < 200);
    chk(tag, 32'(n), 32'(exp_period(m_score)));
  endtask

  task automatic lock_piece(input int sp);
    next_block = 1'b1;
    score_plus = 10'(sp);
    tick();
    chk("lock_strobes", 32'(strobes()), 32'd0);
    chk("lock_playing", 32'(playing), 32'd0);
    m_score = (m_score + sp > 65535) ? 65535 : m_score + sp;
    next_block = 1'b0;
    tick();
    chk("lock_score", 32'(score), 32'(m_score));
    chk("lock_level", 32'(level), 32'(exp_level(m_score)));
    chk("lock_playing_again", 32'(playing), 32'd1);
    chk_block("lock_block");
    g = 0;
  endtask

  initial begin
    seq[0] = SEED;
    for (int i = 1; i < SEQ_N; i++) seq[i] = lfsr_next(seq[i-1]);

    rst_n = 1'b0;
    {btn_left, btn_right, btn_down, btn_rot, btn_start} = '0;
    next_block = 1'b0; gameover = 1'b0; score_plus = '0;
    {lv_l, lv_r, lv_d, lv_rt} = '0;
    m_score = 0; g = 0;
    tick(); tick();
    chk("rst_strobes", 32'(strobes()), 32'd0);
    chk("rst_block", 32'(block_num), 32'd0);
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_playing", 32'(playing), 32'd0);
    chk("rst_over", 32'(over), 32'd0);
    rst_n = 1'b1;
    tick();

    // Buttons are ignored while idle.
    btn_left = 1'b1;
    tick();
    chk("idle_strobes", 32'(strobes()), 32'd0);
    chk("idle_playing", 32'(playing), 32'd0);
    btn_left = 1'b0;
    tick();

    // Start: SPAWN then PLAY two cycles after the edge.
    btn_start = 1'b1;
    tick();
    chk("start_not_yet", 32'(playing), 32'd0);
    tick();
    chk("start_playing", 32'(playing), 32'd1);
    chk("start_score", 32'(score), 32'd0);
    chk_block("start_block");
    btn_start = 1'b0;
    g = 0;

    // Gravity at level 0, then a btn_down edge at count 5.
    measure_gravity("grav_first");
    repeat (5) play_step(1'b0, 1'b0, 1'b0, 1'b0);
    play_step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("btn_down_pulse", 32'(down), 32'd1);
    measure_gravity("grav_after_btn_down");

    // Left and rotate together: rotate wins, held left stays silent.
    play_step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("rot_wins", 32'(ro), 32'd1);
    chk("left_dropped", 32'(left), 32'd0);
    play_step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("left_held", 32'(left), 32'd0);
    play_step(1'b0, 1'b0, 1'b0, 1'b0);
    play_step(1'b1, 1'b1, 1'b0, 1'b0);
    play_step(1'b0, 1'b0, 1'b0, 1'b0);
    play_step(1'b0, 1'b1, 1'b1, 1'b1);
    play_step(1'b0, 1'b0, 1'b0, 1'b0);

    // Randomized play.
    for (int i = 0; i < 300; i++) begin
      play_step(($urandom_range(0, 3) == 0) ? ~lv_l : lv_l,
                ($urandom_range(0, 3) == 0) ? ~lv_r : lv_r,
                ($urandom_range(0, 5) == 0) ? ~lv_d : lv_d,
                ($urandom_range(0, 3) == 0) ? ~lv_rt : lv_rt);
    end
    play_step(1'b0, 1'b0, 1'b0, 1'b0);

    // Scoring, level and gravity speed-up.
    lock_piece(250);
    measure_gravity("grav_level2");
    lock_piece(250);
    lock_piece(250);
    measure_gravity("grav_clamped");
    while (m_score + 1023 < 65500) lock_piece(int'($urandom_range(500, 1023)));
    lock_piece(65500 - m_score);
    chk("score_65500", 32'(score), 32'd65500);
    lock_piece(40);
    chk("score_saturated", 32'(score), 32'd65535);
    measure_gravity("grav_max_level");

    // gameover beats next_block; score frozen, strobes suppressed.
    gameover = 1'b1; next_block = 1'b1; score_plus = 10'd100;
    btn_rot = 1'b1;
    tick();
    chk("go_over", 32'(over), 32'd1);
    chk("go_playing", 32'(playing), 32'd0);
    chk("go_strobes", 32'(strobes()), 32'd0);
    chk("go_score", 32'(score), 32'(m_score));
    gameover = 1'b0; next_block = 1'b0; btn_rot = 1'b0; btn_left = 1'b1;
    tick();
    chk("over_strobes", 32'(strobes()), 32'd0);
    chk("over_hold", 32'(over), 32'd1);
    chk("over_score", 32'(score), 32'(m_score));
    btn_left = 1'b0;
    {lv_l, lv_r, lv_d, lv_rt} = '0;
    tick();

    // Restart from OVER clears score and level.
    btn_start = 1'b1;
    tick();
    m_score = 0;
    chk("restart_score", 32'(score), 32'd0);
    chk("restart_level", 32'(level), 32'd0);
    chk("restart_over", 32'(over), 32'd0);
    tick();
    chk("restart_playing", 32'(playing), 32'd1);
    chk_block("restart_block");
    g = 0;
    btn_start = 1'b0;

    // gameover during SPAWN.
    next_block = 1'b1; score_plus = 10'd7;
    tick();
    m_score = 7;
    next_block = 1'b0; gameover = 1'b1;
    tick();
    chk("spawn_go_over", 32'(over), 32'd1);
    chk("spawn_go_playing", 32'(playing), 32'd0);
    chk("spawn_go_score", 32'(score), 32'(m_score));
    gameover = 1'b0;
    tick();

    // Restart, play a little, then reset mid-game with a button press.
    btn_start = 1'b1;
    tick(); tick();
    m_score = 0; g = 0;
    btn_start = 1'b0;
    repeat (3) play_step(1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    btn_down = 1'b1;
    tick();
    chk("midrst_strobes", 32'(strobes()), 32'd0);
    chk("midrst_playing", 32'(playing), 32'd0);
    chk("midrst_score", 32'(score), 32'd0);
    chk("midrst_block", 32'(block_num), 32'd0);
    rst_n = 1'b1;
    btn_down = 1'b0;
    tick();
    chk("postrst_strobes", 32'(strobes()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
